// File: rtl/gol_pkg.sv
// Shared types and Life rule constants for the gol_grid cellular automaton.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam int BIRTH      = 3;
  localparam int SURVIVE_LO = 2;
  localparam int SURVIVE_HI = 3;

endpackage

// File: rtl/gol_cell.sv
// One Life cell: live-neighbour count plus current state -> next state (B3/S23).
module gol_cell
  import gol_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       cur,
  output logic       nxt
);

  logic [3:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, nbr[i]};
    if (cur) nxt = (cnt >= 4'(SURVIVE_LO)) && (cnt <= 4'(SURVIVE_HI));
    else     nxt = (cnt == 4'(BIRTH));
  end

endmodule

// File: rtl/gol_grid.sv
// ROWSxCOLS Game of Life engine: one generation per clock in RUN, single-step in IDLE,
// halts on still life, extinction, generation limit or counter saturation.
module gol_grid
  import gol_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [ROWS-1:0][COLS-1:0]  init_grid,
  input  logic                       run,
  input  logic                       step,
  input  logic                       wrap,
  input  logic [GEN_W-1:0]           max_gen,
  output logic [ROWS-1:0][COLS-1:0]  grid,
  output logic [GEN_W-1:0]           gen_count,
  output logic                       busy,
  output logic                       done,
  output logic                       stable,
  output logic                       extinct
);

  logic [ROWS-1:0][COLS-1:0] grid_q, grid_d, next;
  logic [GEN_W-1:0]          gen_q, gen_d, gen_inc;
  state_e                    state_q, state_d;
  logic                      stable_q, stable_d;
  logic                      extinct_q, extinct_d;
  logic                      next_same, next_zero, hit_max, eval;

  // Torus neighbour indices are fixed per cell; with wrap=0 the edge taps are masked off.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RU = (r == 0)        ? ROWS - 1 : r - 1;
      localparam int RD = (r == ROWS - 1) ? 0        : r + 1;
      localparam int CL = (c == 0)        ? COLS - 1 : c - 1;
      localparam int CR = (c == COLS - 1) ? 0        : c + 1;
      localparam bit TOP = (r == 0);
      localparam bit BOT = (r == ROWS - 1);
      localparam bit LFT = (c == 0);
      localparam bit RGT = (c == COLS - 1);

      logic       up_ok, dn_ok, lf_ok, rt_ok;
      logic [7:0] nbr;

      assign up_ok = wrap | ~TOP;
      assign dn_ok = wrap | ~BOT;
      assign lf_ok = wrap | ~LFT;
      assign rt_ok = wrap | ~RGT;

      assign nbr = {grid_q[RU][CL] & up_ok & lf_ok,
                    grid_q[RU][c]  & up_ok,
                    grid_q[RU][CR] & up_ok & rt_ok,
                    grid_q[r][CL]  & lf_ok,
                    grid_q[r][CR]  & rt_ok,
                    grid_q[RD][CL] & dn_ok & lf_ok,
                    grid_q[RD][c]  & dn_ok,
                    grid_q[RD][CR] & dn_ok & rt_ok};

      gol_cell u_cell (
        .nbr (nbr),
        .cur (grid_q[r][c]),
        .nxt (next[r][c])
      );
    end
  end

  assign next_same = (next == grid_q);
  assign next_zero = ~|next;
  assign gen_inc   = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
  assign hit_max   = (max_gen != '0) && (gen_inc == max_gen);

  always_comb begin
    grid_d    = grid_q;
    gen_d     = gen_q;
    state_d   = state_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    eval      = 1'b0;

    if (load) begin
      grid_d    = init_grid;
      gen_d     = '0;
      state_d   = IDLE;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (run) state_d = RUN; else if (step) eval = 1'b1;
        RUN:     if (!run) state_d = IDLE; else eval = 1'b1;
        default: ;
      endcase

      if (eval) begin
        if (next_zero) extinct_d = 1'b1;
        if (next_same) begin
          // Still life (including an empty grid): hold the pattern and the count.
          stable_d = 1'b1;
          if (state_q == RUN) state_d = HALT;
        end else begin
          grid_d = next;
          gen_d  = gen_inc;
          if (state_q == RUN && (next_zero || hit_max || (&gen_inc))) state_d = HALT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_q    <= '0;
      gen_q     <= '0;
      state_q   <= IDLE;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      state_q   <= state_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == HALT);
  assign stable    = stable_q;
  assign extinct   = extinct_q;

endmodule

// File: tb/tb_gol_grid.sv
// Bench for gol_grid: 8x8 step vectors against a reference Life model, plus 5x5/3x3 corner sequences.
module tb_gol_grid;

  typedef logic [7:0][7:0] g8_t;
  typedef struct {
    g8_t  init;
    logic wrap;
    int   steps;
    int   exp_gen;
    logic exp_st;
    logic exp_ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic l8, r8, s8, w8, b8, d8, st8, ex8;
  g8_t  i8, o8;
  logic [15:0] mg8, gc8;

  logic l5, r5, s5, w5, b5, d5, st5, ex5;
  logic [4:0][4:0] i5, o5, e5;
  logic [15:0] mg5, gc5;

  logic l3, r3, s3, w3, b3, d3, st3, ex3;
  logic [2:0][2:0] i3, o3;
  logic [2:0] mg3, gc3;

  gol_grid #(.ROWS(8), .COLS(8), .GEN_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .load(l8), .init_grid(i8), .run(r8), .step(s8), .wrap(w8),
    .max_gen(mg8), .grid(o8), .gen_count(gc8), .busy(b8), .done(d8), .stable(st8), .extinct(ex8));

  gol_grid #(.ROWS(5), .COLS(5), .GEN_W(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .load(l5), .init_grid(i5), .run(r5), .step(s5), .wrap(w5),
    .max_gen(mg5), .grid(o5), .gen_count(gc5), .busy(b5), .done(d5), .stable(st5), .extinct(ex5));

  gol_grid #(.ROWS(3), .COLS(3), .GEN_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load(l3), .init_grid(i3), .run(r3), .step(s3), .wrap(w3),
    .max_gen(mg3), .grid(o3), .gen_count(gc3), .busy(b3), .done(d3), .stable(st3), .extinct(ex3));

  int  total = 0;
  int  bad   = 0;
  g8_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: count neighbours directly, B3/S23.
  function automatic g8_t model(input g8_t g, input logic w);
    g8_t n;
    int  cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (w) begin rr = (rr + 8) % 8; cc = (cc + 8) % 8; end
            if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) cnt += int'(g[rr][cc]);
          end
        n[r][c] = g[r][c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
      end
    return n;
  endfunction

  initial begin
    vec_t tv[5];
    g8_t  blk, blink, glider, cur;
    int   n;

    rst_n = 1'b1;
    {l8, r8, s8, w8} = '0; i8 = '0; mg8 = '0;
    {l5, r5, s5, w5} = '0; i5 = '0; mg5 = '0;
    {l3, r3, s3, w3} = '0; i3 = '0; mg3 = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grid", 64'(o8), 64'(0));
    chk("rst_gen", 64'(gc8), 64'(0));
    chk("rst_flags", 64'({b8, d8, st8, ex8}), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    blink = '0; blink[3] = 8'b0001_1100;
    blk   = '0; blk[3]   = 8'b0001_1000; blk[4] = 8'b0001_1000;
    tv[0] = '{init: blink, wrap: 1'b0, steps: 4, exp_gen: 4, exp_st: 1'b0, exp_ex: 1'b0};
    tv[1] = '{init: blk,   wrap: 1'b0, steps: 2, exp_gen: 0, exp_st: 1'b1, exp_ex: 1'b0};
    cur = '0; cur[7] = 8'h01; cur[0] = 8'h01; cur[1] = 8'h01;
    tv[2] = '{init: cur,   wrap: 1'b1, steps: 3, exp_gen: 3, exp_st: 1'b0, exp_ex: 1'b0};
    tv[3] = '{init: cur,   wrap: 1'b0, steps: 2, exp_gen: 1, exp_st: 1'b1, exp_ex: 1'b1};
    cur = '0; cur[0] = 8'b0000_0011; cur[1] = 8'b0000_0001;
    tv[4] = '{init: cur,   wrap: 1'b0, steps: 2, exp_gen: 1, exp_st: 1'b1, exp_ex: 1'b0};

    for (int v = 0; v < 5; v++) begin
      l8 = 1'b1; i8 = tv[v].init; w8 = tv[v].wrap;
      tick();
      l8 = 1'b0;
      chk($sformatf("v%0d_load", v), 64'(o8), 64'(tv[v].init));
      chk($sformatf("v%0d_clr", v), 64'({st8, ex8, gc8}), 64'(0));
      cur = tv[v].init;
      for (int k = 0; k < tv[v].steps; k++) begin
        cur = model(cur, tv[v].wrap);
        exp_q.push_back(cur);
        s8 = 1'b1;
        tick();
        s8 = 1'b0;
        chk($sformatf("v%0d_s%0d_grid", v, k), 64'(o8), 64'(exp_q.pop_front()));
        tick();
      end
      chk($sformatf("v%0d_gen", v), 64'(gc8), 64'(tv[v].exp_gen));
      chk($sformatf("v%0d_st", v), 64'(st8), 64'(tv[v].exp_st));
      chk($sformatf("v%0d_ex", v), 64'(ex8), 64'(tv[v].exp_ex));
      chk($sformatf("v%0d_idle", v), 64'({b8, d8}), 64'(0));
    end

    // run drop leaves RUN without an update
    l8 = 1'b1; i8 = blink; w8 = 1'b0; mg8 = '0;
    tick(); l8 = 1'b0; r8 = 1'b1;
    tick();
    chk("run_busy", 64'(b8), 64'(1));
    tick(); r8 = 1'b0;
    tick();
    chk("run_stop_busy", 64'(b8), 64'(0));
    chk("run_stop_gen", 64'(gc8), 64'(1));
    chk("run_stop_grid", 64'(o8), 64'(model(blink, 1'b0)));

    // still life in RUN
    l8 = 1'b1; i8 = blk;
    tick(); l8 = 1'b0; r8 = 1'b1;
    tick();
    chk("blk_st0", 64'(st8), 64'(0));
    tick();
    chk("blk_st", 64'(st8), 64'(1));
    chk("blk_done", 64'(d8), 64'(1));
    chk("blk_gen", 64'(gc8), 64'(0));
    chk("blk_grid", 64'(o8), 64'(blk));
    r8 = 1'b0;

    // glider on torus returns home after 32 generations
    glider = '0; glider[0] = 8'b0000_0010; glider[1] = 8'b0000_0100; glider[2] = 8'b0000_0111;
    l8 = 1'b1; i8 = glider; w8 = 1'b1; mg8 = 16'd32;
    tick(); l8 = 1'b0; r8 = 1'b1;
    n = 0;
    while (!d8 && n < 80) begin tick(); n++; end
    chk("gli_done", 64'(d8), 64'(1));
    chk("gli_gen", 64'(gc8), 64'(32));
    cur = glider;
    for (int k = 0; k < 32; k++) cur = model(cur, 1'b1);
    chk("gli_model", 64'(o8), 64'(cur));
    chk("gli_home", 64'(o8), 64'(glider));
    r8 = 1'b0; s8 = 1'b1;
    tick(); s8 = 1'b0;
    chk("halt_step_gen", 64'(gc8), 64'(32));
    chk("halt_hold", 64'(d8), 64'(1));

    // 3x3 torus: all-ones then extinction
    for (int r = 0; r < 3; r++) i3[r] = 3'b010;
    l3 = 1'b1; w3 = 1'b1;
    tick(); l3 = 1'b0; r3 = 1'b1;
    tick(); tick();
    chk("t3_full", 64'(o3), 64'(9'h1FF));
    chk("t3_gen1", 64'(gc3), 64'(1));
    tick();
    chk("t3_zero", 64'(o3), 64'(0));
    chk("t3_ex", 64'(ex3), 64'(1));
    chk("t3_done", 64'(d3), 64'(1));
    chk("t3_gen2", 64'(gc3), 64'(2));

    // 3x3 bounded blinker oscillates until the 3-bit counter saturates
    l3 = 1'b1; w3 = 1'b0;
    tick(); l3 = 1'b0;
    chk("b3_load", 64'({b3, d3, ex3, gc3}), 64'(0));
    tick();
    repeat (4) tick();
    chk("b3_busy", 64'(b3), 64'(1));
    chk("b3_gen4", 64'(gc3), 64'(4));
    chk("b3_vert", 64'(o3), 64'(9'h092));
    repeat (3) tick();
    chk("b3_sat_done", 64'(d3), 64'(1));
    chk("b3_sat_gen", 64'(gc3), 64'(7));
    chk("b3_horz", 64'(o3), 64'(9'h038));
    tick();
    chk("b3_sat_hold", 64'(gc3), 64'(7));
    r3 = 1'b0;

    // 5x5 blinker stepping
    i5 = '0; i5[1] = 5'b00100; i5[2] = 5'b00100; i5[3] = 5'b00100;
    l5 = 1'b1; w5 = 1'b0;
    tick(); l5 = 1'b0; s5 = 1'b1;
    tick(); s5 = 1'b0;
    e5 = '0; e5[2] = 5'b01110;
    chk("b5_s1", 64'(o5), 64'(e5));
    chk("b5_g1", 64'(gc5), 64'(1));
    tick(); s5 = 1'b1;
    tick(); s5 = 1'b0;
    chk("b5_s2", 64'(o5), 64'(i5));
    chk("b5_g2", 64'(gc5), 64'(2));

    // load mid-RUN, then asynchronous reset mid-RUN
    l5 = 1'b1;
    tick(); l5 = 1'b0; r5 = 1'b1;
    tick();
    repeat (5) tick();
    chk("b5_run5", 64'(gc5), 64'(5));
    l5 = 1'b1;
    tick(); l5 = 1'b0;
    chk("b5_ld_grid", 64'(o5), 64'(i5));
    chk("b5_ld_gen", 64'(gc5), 64'(0));
    chk("b5_ld_idle", 64'(b5), 64'(0));
    tick(); tick();
    chk("b5_rerun", 64'(b5), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_grid", 64'(o5), 64'(0));
    chk("rst_async_flags", 64'({b5, d5, st5, ex5, gc5}), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_rel_idle", 64'(b5), 64'(0));
    tick();
    chk("rst_rel_run", 64'(b5), 64'(1));
    chk("rst_rel_grid", 64'(o5), 64'(0));
    r5 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
